// File: rtl/histogram_compressor.sv
// Frame histogram of {stream_a,stream_b} bit pairs.
// Counts STREAM_LENGTH accepted pairs into four bins, then holds them for the consumer.
module histogram_compressor #(
    parameter int STREAM_LENGTH = 128,
    parameter int COUNTER_WIDTH = $clog2(STREAM_LENGTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_compress,
    input  logic                     abort,
    input  logic                     in_valid,
    input  logic                     stream_a,
    input  logic                     stream_b,
    output logic                     in_ready,
    output logic [COUNTER_WIDTH-1:0] count_00,
    output logic [COUNTER_WIDTH-1:0] count_01,
    output logic [COUNTER_WIDTH-1:0] count_10,
    output logic [COUNTER_WIDTH-1:0] count_11,
    output logic                     hist_valid,
    input  logic                     hist_ready,
    output logic                     busy
);

    localparam int PW = $clog2(STREAM_LENGTH + 1);
    localparam logic [PW-1:0] LAST_PAIR = PW'(STREAM_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            pair_q, pair_d;
    logic [COUNTER_WIDTH-1:0] bin_q [4];
    logic [COUNTER_WIDTH-1:0] bin_d [4];
    logic [1:0]               sel;

    assign sel = {stream_a, stream_b};

    // Outputs decoded from registered state and bins only
    assign in_ready   = (state_q == ACCUM);
    assign busy       = (state_q == ACCUM);
    assign hist_valid = (state_q == HOLD);
    assign count_00   = bin_q[0];
    assign count_01   = bin_q[1];
    assign count_10   = bin_q[2];
    assign count_11   = bin_q[3];

    // Next-state, bin and pair-counter update
    always_comb begin
        state_d = state_q;
        pair_d  = pair_q;
        for (int i = 0; i < 4; i++) bin_d[i] = bin_q[i];
        unique case (state_q)
            IDLE: begin
                if (start_compress) begin
                    state_d = ACCUM;
                    pair_d  = '0;
                    for (int i = 0; i < 4; i++) bin_d[i] = '0;
                end
            end
            ACCUM: begin
                if (abort) begin
                    state_d = IDLE;
                    pair_d  = '0;
                    for (int i = 0; i < 4; i++) bin_d[i] = '0;
                end else if (in_valid) begin
                    bin_d[sel] = bin_q[sel] + COUNTER_WIDTH'(1);
                    pair_d     = pair_q + PW'(1);
                    if (pair_q == LAST_PAIR) state_d = HOLD;
                end
            end
            HOLD: begin
                if (hist_ready) begin
                    if (start_compress) begin
                        state_d = ACCUM;
                        pair_d  = '0;
                        for (int i = 0; i < 4; i++) bin_d[i] = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pair counter and bins; async reset clears any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pair_q  <= '0;
            for (int i = 0; i < 4; i++) bin_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            for (int i = 0; i < 4; i++) bin_q[i] <= bin_d[i];
        end
    end

endmodule

// File: tb/tb_histogram_compressor.sv
// Bench for histogram_compressor, STREAM_LENGTH=8.
// Reference model keeps the accepted pairs of the frame in a queue and tallies them.
module tb_histogram_compressor;

    localparam int SL = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_compress = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          stream_a = 1'b0;
    logic          stream_b = 1'b0;
    logic          hist_ready = 1'b0;
    logic          in_ready;
    logic          hist_valid;
    logic          busy;
    logic [CW-1:0] count_00, count_01, count_10, count_11;

    int n_tests = 0;
    int n_fail  = 0;

    // model: mode 0=idle 1=accumulating 2=holding
    int mode = 0;
    int q[$];

    histogram_compressor #(
        .STREAM_LENGTH(SL),
        .COUNTER_WIDTH(CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_compress(start_compress),
        .abort         (abort),
        .in_valid      (in_valid),
        .stream_a      (stream_a),
        .stream_b      (stream_b),
        .in_ready      (in_ready),
        .count_00      (count_00),
        .count_01      (count_01),
        .count_10      (count_10),
        .count_11      (count_11),
        .hist_valid    (hist_valid),
        .hist_ready    (hist_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int tally(input int v);
        int n = 0;
        foreach (q[i]) if (q[i] == v) n++;
        return n;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ":in_ready"}, int'(in_ready), int'(mode == 1));
        chk({tag, ":busy"}, int'(busy), int'(mode == 1));
        chk({tag, ":hist_valid"}, int'(hist_valid), int'(mode == 2));
        chk({tag, ":c00"}, int'(count_00), tally(0));
        chk({tag, ":c01"}, int'(count_01), tally(1));
        chk({tag, ":c10"}, int'(count_10), tally(2));
        chk({tag, ":c11"}, int'(count_11), tally(3));
        if (mode == 2)
            chk({tag, ":sum"},
                int'(count_00) + int'(count_01) + int'(count_10) + int'(count_11), SL);
    endtask

    task automatic model_clock();
        case (mode)
            0: if (start_compress) begin
                q.delete();
                mode = 1;
            end
            1: if (abort) begin
                q.delete();
                mode = 0;
            end else if (in_valid) begin
                q.push_back(int'({stream_a, stream_b}));
                if (q.size() == SL) mode = 2;
            end
            default: if (hist_ready) begin
                if (start_compress) begin
                    q.delete();
                    mode = 1;
                end else begin
                    mode = 0;
                end
            end
        endcase
    endtask

    task automatic set_in(input bit st, input bit ab, input bit v,
                          input int p, input bit hr);
        start_compress = st;
        abort          = ab;
        in_valid       = v;
        stream_a       = p[1];
        stream_b       = p[0];
        hist_ready     = hr;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        q.delete();
        mode = 0;
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input string tag, input int pairs[8], input bit gaps);
        set_in(1, 0, 0, 0, 0);
        step({tag, "_start"});
        for (int i = 0; i < SL; i++) begin
            if (gaps) begin
                set_in(0, 0, 0, 3, 0);
                step({tag, "_gap"});
            end
            set_in(0, 0, 1, pairs[i], 0);
            step({tag, "_pair"});
        end
        set_in(0, 0, 0, 0, 0);
    endtask

    int basic[8]  = '{0, 1, 2, 3, 3, 2, 3, 0};
    int ones01[8] = '{1, 1, 1, 1, 1, 1, 1, 1};

    initial begin
        #12;
        check_all("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step("idle");

        // reset mid-accumulation after 3 pairs
        set_in(1, 0, 0, 0, 0);
        step("r_start");
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1, 3, 0);
            step("r_pair");
        end
        do_reset("r_async");
        set_in(0, 0, 1, 2, 0);
        step("r_after1");
        step("r_after2");

        // basic frame, then release
        run_frame("basic", basic, 0);
        chk("basic_c11", int'(count_11), 3);
        set_in(0, 0, 0, 0, 1);
        step("basic_release");

        // frame with gaps, then backpressure in HOLD
        run_frame("gaps", basic, 1);
        chk("gaps_c00", int'(count_00), 2);
        for (int i = 0; i < 5; i++) begin
            set_in(1, 1, 1, 3, 0);
            step("bp_hold");
        end
        set_in(0, 0, 1, 3, 1);
        step("bp_release");
        chk("bp_idle", int'(hist_valid), 0);

        // abort wins over accept
        set_in(1, 0, 0, 0, 0);
        step("ab_start");
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1, 2, 0);
            step("ab_pair");
        end
        set_in(0, 1, 1, 2, 0);
        step("ab_abort");
        chk("ab_c10", int'(count_10), 0);
        run_frame("after_ab", ones01, 0);
        chk("after_ab_c01", int'(count_01), 8);

        // back-to-back frames, start ignored while accumulating
        set_in(1, 0, 0, 0, 1);
        step("b2b_restart");
        chk("b2b_ready", int'(in_ready), 1);
        for (int i = 0; i < SL; i++) begin
            set_in(i[0], 0, 1, i % 4, 0);
            step("b2b_pair");
        end
        chk("b2b_hold", int'(hist_valid), 1);
        set_in(0, 0, 0, 0, 1);
        step("b2b_release");

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset("rnd_reset");
            end
            set_in($urandom_range(0, 99) < 20,
                   $urandom_range(0, 99) < 3,
                   $urandom_range(0, 99) < 60,
                   int'($urandom_range(0, 3)),
                   $urandom_range(0, 99) < 40);
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
